// File: rtl/mem_arbiter.sv
// mem_arbiter: data-priority arbiter sharing one variable-latency memory between fetch and data ports
module mem_arbiter #(
  parameter int WIDTH = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_req,
  input  logic [WIDTH-1:0] i_addr,
  output logic [WIDTH-1:0] i_rdata,
  output logic             i_done,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [WIDTH-1:0] d_addr,
  input  logic [WIDTH-1:0] d_wdata,
  input  logic [3:0]       d_be,
  output logic [WIDTH-1:0] d_rdata,
  output logic             d_done,
  output logic             m_req,
  output logic             m_we,
  output logic [WIDTH-1:0] m_addr,
  output logic [WIDTH-1:0] m_wdata,
  output logic [3:0]       m_be,
  input  logic             m_ack,
  input  logic [WIDTH-1:0] m_rdata,
  output logic             stall_f,
  output logic             stall_m
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);
  typedef enum logic [1:0] {IDLE, D_WAIT, I_WAIT, RESP} state_t;
  state_t state;
  logic [CW-1:0] starve_cnt;
  logic i_win;
  assign i_win = i_req && (!d_req || starve_cnt == LIM);
  assign stall_f = i_req & ~i_done;
  assign stall_m = d_req & ~d_done;
  // RESP separates each done pulse from the next arbitration so a still-high req is not re-served
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      starve_cnt <= '0;
      m_req <= 1'b0;
      m_we <= 1'b0;
      m_addr <= '0;
      m_wdata <= '0;
      m_be <= 4'b0000;
      i_done <= 1'b0;
      d_done <= 1'b0;
      i_rdata <= '0;
      d_rdata <= '0;
    end else begin
      i_done <= 1'b0;
      d_done <= 1'b0;
      case (state)
        IDLE:
          if (i_win) begin
            m_addr <= i_addr;
            m_we <= 1'b0;
            m_be <= 4'b1111;
            m_req <= 1'b1;
            starve_cnt <= '0;
            state <= I_WAIT;
          end else if (d_req) begin
            m_addr <= d_addr;
            m_wdata <= d_wdata;
            m_be <= d_be;
            m_we <= d_we;
            m_req <= 1'b1;
            starve_cnt <= !i_req ? '0 : starve_cnt == LIM ? starve_cnt : starve_cnt + 1'b1;
            state <= D_WAIT;
          end
        D_WAIT:
          if (m_ack) begin
            m_req <= 1'b0;
            d_done <= 1'b1;
            d_rdata <= m_we ? d_rdata : m_rdata;
            state <= RESP;
          end
        I_WAIT:
          if (m_ack) begin
            m_req <= 1'b0;
            i_done <= 1'b1;
            i_rdata <= m_rdata;
            state <= RESP;
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench with requester and memory models for mem_arbiter
module tb_mem_arbiter;
  typedef struct packed {logic we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] be;} acc_t;
  typedef struct packed {logic port; logic [31:0] data;} cmp_t;
  logic clk = 0, rst = 1;
  logic i_req = 0, i_done, d_req = 0, d_we = 0, d_done, m_req, m_we, m_ack = 0, stall_f, stall_m;
  logic [31:0] i_addr = 0, i_rdata, d_addr = 0, d_wdata = 0, d_rdata, m_addr, m_wdata, m_rdata = 0;
  logic [3:0] d_be = 0, m_be;
  int errors = 0, checks = 0, lat = 1, wait_cnt = 0, mlen = 0, last_len = 0;
  bit mem_auto = 1, prev_mreq = 0;
  logic smp_i_done, smp_d_done, smp_stall_f, smp_m_req;
  logic [68:0] held;
  logic [31:0] last_load = 0;
  acc_t acc_q[$], d_q[$];
  cmp_t cmp_q[$];
  logic [31:0] i_q[$];

  mem_arbiter #(.WIDTH(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst), .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be), .d_rdata(d_rdata),
    .d_done(d_done), .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
    .m_ack(m_ack), .m_rdata(m_rdata), .stall_f(stall_f), .stall_m(stall_m));

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_data(logic [31:0] a);
    return a == 32'h100 ? 32'h00500093 : a ^ 32'hC0DE0000;
  endfunction

  function automatic acc_t mk(logic we, logic [31:0] a, logic [31:0] wd, logic [3:0] be);
    return {we, a, wd, be};
  endfunction

  function automatic cmp_t load_cmp(logic [31:0] a);
    last_load = mem_data(a);
    return {1'b0, last_load};
  endfunction

  task automatic tick();
    acc_t e;
    cmp_t c;
    @(negedge clk);
    smp_i_done = i_done; smp_d_done = d_done; smp_stall_f = stall_f; smp_m_req = m_req;
    if (m_req && !prev_mreq) begin
      checks++;
      mlen = 1;
      held = {m_we, m_addr, m_wdata, m_be};
      if (acc_q.size() == 0) begin
        errors++; $display("FAIL access: unexpected access addr=%h, none expected", m_addr);
      end else begin
        e = acc_q.pop_front();
        if ({m_we, m_addr, m_be, m_we ? m_wdata : 32'h0} !== {e.we, e.addr, e.be, e.we ? e.wdata : 32'h0}) begin
          errors++;
          $display("FAIL access: got we=%b addr=%h be=%b wdata=%h want we=%b addr=%h be=%b wdata=%h",
                   m_we, m_addr, m_be, m_wdata, e.we, e.addr, e.be, e.wdata);
        end
      end
    end else if (m_req) begin
      checks++;
      mlen++;
      if ({m_we, m_addr, m_wdata, m_be} !== held) begin
        errors++; $display("FAIL m_stable: got %h want %h", {m_we, m_addr, m_wdata, m_be}, held);
      end
    end else if (prev_mreq) last_len = mlen;
    if (i_done || d_done) begin
      checks++;
      if (cmp_q.size() == 0) begin
        errors++; $display("FAIL done: unexpected i_done=%b d_done=%b", i_done, d_done);
      end else begin
        c = cmp_q.pop_front();
        if ({i_done, d_done, i_done ? i_rdata : d_rdata} !== {c.port, !c.port, c.data}) begin
          errors++;
          $display("FAIL done: got i_done=%b d_done=%b data=%h want fetch=%b data=%h",
                   i_done, d_done, i_done ? i_rdata : d_rdata, c.port, c.data);
        end
      end
    end
    prev_mreq = m_req;
    @(posedge clk);
    #1;
    if (smp_i_done) i_req = 0;
    if (smp_d_done) d_req = 0;
    if (!i_req && i_q.size() != 0) begin i_addr = i_q.pop_front(); i_req = 1; end
    if (!d_req && d_q.size() != 0) begin
      e = d_q.pop_front();
      d_we = e.we; d_addr = e.addr; d_wdata = e.wdata; d_be = e.be; d_req = 1;
    end
    if (mem_auto) begin
      wait_cnt = m_req ? wait_cnt + 1 : 0;
      m_ack = m_req && wait_cnt == lat;
      m_rdata = mem_data(m_addr);
    end
  endtask

  task automatic run_until_done(int bound);
    int n = 0;
    while ((acc_q.size() || cmp_q.size() || i_q.size() || d_q.size() || i_req || d_req) && n < bound) begin
      tick(); n++;
    end
    checks++;
    if (n >= bound) begin
      errors++;
      $display("FAIL timeout: acc=%0d cmp=%0d pending after %0d cycles", acc_q.size(), cmp_q.size(), bound);
      acc_q.delete(); cmp_q.delete(); i_q.delete(); d_q.delete(); i_req = 0; d_req = 0;
    end
  endtask

  task automatic test_reset();
    rst = 1;
    tick(); tick();
    checks++;
    if ({m_req, m_we, i_done, d_done, m_addr, m_wdata, i_rdata, d_rdata, m_be, stall_f, stall_m} !== '0) begin
      errors++;
      $display("FAIL reset: got m_req=%b m_we=%b addr=%h wdata=%h be=%b i_rdata=%h d_rdata=%h want all 0",
               m_req, m_we, m_addr, m_wdata, m_be, i_rdata, d_rdata);
    end
    checks++;
    if (dut.starve_cnt !== 0) begin errors++; $display("FAIL reset_starve: got %0d want 0", dut.starve_cnt); end
    rst = 0;
  endtask

  task automatic test_fetch();
    int k = 0;
    bit found = 0;
    lat = 1;
    i_q.push_back(32'h100);
    acc_q.push_back(mk(0, 32'h100, 0, 4'b1111));
    cmp_q.push_back({1'b1, 32'h00500093});
    tick();
    for (int n = 0; n < 20 && !found; n++) begin
      tick();
      if (smp_i_done) found = 1;
      else begin
        k++; checks++;
        if (smp_stall_f !== 1'b1) begin errors++; $display("FAIL fetch_stall: got %b want 1", smp_stall_f); end
      end
    end
    checks++;
    if (!found || k != 2) begin errors++; $display("FAIL fetch_latency: got %0d cycles found=%b want 2", k, found); end
    checks++;
    if (smp_stall_f !== 1'b0) begin errors++; $display("FAIL fetch_stall_done: got %b want 0", smp_stall_f); end
    tick();
    checks++;
    if (smp_i_done !== 1'b0) begin errors++; $display("FAIL fetch_pulse: i_done got %b want 0", smp_i_done); end
    run_until_done(20);
  endtask

  task automatic test_simultaneous();
    lat = 2;
    i_q.push_back(32'h200);
    d_q.push_back(mk(0, 32'h1000, 0, 4'b1111));
    acc_q.push_back(mk(0, 32'h1000, 0, 4'b1111));
    acc_q.push_back(mk(0, 32'h200, 0, 4'b1111));
    cmp_q.push_back(load_cmp(32'h1000));
    cmp_q.push_back({1'b1, mem_data(32'h200)});
    run_until_done(60);
  endtask

  task automatic test_starvation();
    lat = 1;
    for (int j = 0; j < 6; j++) d_q.push_back(mk(0, 32'h3000 + 32'(j * 4), 0, 4'b1111));
    i_q.push_back(32'h400);
    for (int j = 0; j < 6; j++) begin
      if (j == 4) begin
        acc_q.push_back(mk(0, 32'h400, 0, 4'b1111));
        cmp_q.push_back({1'b1, mem_data(32'h400)});
      end
      acc_q.push_back(mk(0, 32'h3000 + 32'(j * 4), 0, 4'b1111));
      cmp_q.push_back(load_cmp(32'h3000 + 32'(j * 4)));
    end
    run_until_done(200);
    checks++;
    if (dut.starve_cnt !== 0) begin errors++; $display("FAIL starve_clear: got %0d want 0", dut.starve_cnt); end
  endtask

  task automatic test_store();
    lat = 3;
    d_q.push_back(mk(1, 32'h2004, 32'hDEADBEEF, 4'b0011));
    acc_q.push_back(mk(1, 32'h2004, 32'hDEADBEEF, 4'b0011));
    cmp_q.push_back({1'b0, last_load});
    run_until_done(40);
    checks++;
    if (last_len != 3) begin errors++; $display("FAIL store_hold: m_req cycles got %0d want 3", last_len); end
  endtask

  task automatic test_reset_mid();
    mem_auto = 0; m_ack = 0;
    d_q.push_back(mk(0, 32'h5000, 0, 4'b1111));
    acc_q.push_back(mk(0, 32'h5000, 0, 4'b1111));
    for (int n = 0; n < 10 && !smp_m_req; n++) tick();
    checks++;
    if (smp_m_req !== 1'b1) begin errors++; $display("FAIL rst_mid_grant: m_req got %b want 1", smp_m_req); end
    rst = 1; d_req = 0;
    tick();
    rst = 0; m_ack = 1; m_rdata = 32'h1111_2222;
    tick();
    checks++;
    if (smp_m_req !== 1'b0) begin errors++; $display("FAIL rst_mid_mreq: got %b want 0", smp_m_req); end
    m_ack = 0;
    tick(); tick();
    checks++;
    if ({smp_m_req, smp_d_done, dut.state} !== '0) begin
      errors++; $display("FAIL rst_mid_idle: m_req=%b d_done=%b state=%0d want 0 0 0", smp_m_req, smp_d_done, dut.state);
    end
    checks++;
    if (d_rdata !== 32'h0) begin errors++; $display("FAIL rst_mid_rdata: got %h want 0", d_rdata); end
  endtask

  task automatic test_spurious_ack();
    m_ack = 1; m_rdata = 32'h3333_4444;
    tick();
    m_ack = 0;
    tick();
    checks++;
    if ({smp_m_req, smp_i_done, smp_d_done, m_addr, m_be, m_we, dut.state} !== '0) begin
      errors++;
      $display("FAIL spurious_ack: m_req=%b i_done=%b d_done=%b addr=%h be=%b state=%0d want all 0",
               smp_m_req, smp_i_done, smp_d_done, m_addr, m_be, dut.state);
    end
    mem_auto = 1; wait_cnt = 0;
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_simultaneous();
    test_starvation();
    test_store();
    test_reset_mid();
    test_spurious_ack();
    test_fetch();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
